// File: rtl/tone_gen.sv
// tone_gen: N_CH time-multiplexed phase-accumulator oscillators with bus-mapped FREQ/CTRL registers.
// Optional noise waveform (16-bit LFSR) is built when TONE_GEN_NOISE_EN is defined.
module tone_gen #(
   parameter int N_CH = 8,
   parameter int DIV  = 256
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        valid,
   output logic        ready,
   input  logic [3:0]  wstrb,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic [7:0]  ch0,
   output logic [7:0]  ch1,
   output logic [7:0]  ch2,
   output logic [7:0]  ch3,
   output logic [7:0]  ch4,
   output logic [7:0]  ch5,
   output logic [7:0]  ch6,
   output logic [7:0]  ch7,
   output logic        frame
);

   localparam int FCW = $clog2(DIV);
   localparam logic [3:0] NCH4 = 4'(N_CH);

   typedef enum logic [2:0] {
      W_OFF    = 3'd0,
      W_SQUARE = 3'd1,
      W_SAW    = 3'd2,
      W_TRI    = 3'd3,
      W_NOISE  = 3'd4
   } wave_e;

   logic [15:0]    r_freq  [8];
   logic [2:0]     r_wave  [8];
   logic [7:0]     r_duty  [8];
   logic [15:0]    r_phase [8];
   logic [7:0]     r_ch    [8];
   logic [FCW-1:0] r_fc;
   logic           r_ready;
   logic [31:0]    r_rdata;
   logic           r_frame;
`ifdef TONE_GEN_NOISE_EN
   logic [15:0]    r_lfsr;
   logic           w_lfsr_fb;
   logic           w_is_noise;
`endif

   logic           w_acc;
   logic           w_wr;
   logic [2:0]     w_idx;
   logic           w_sel;
   logic           w_idx_ok;
   logic [31:0]    w_rd_val;
   logic           w_slot_hit;
   logic [2:0]     w_slot;
   logic [15:0]    w_ph;
   logic [7:0]     w_p;
   logic [7:0]     w_sample;
   logic           w_kill;
   logic           w_unused_bits;

   assign w_acc    = valid & ~r_ready;
   assign w_wr     = |wstrb;
   assign w_idx    = addr[4:2];
   assign w_sel    = addr[5];
   assign w_idx_ok = ({1'b0, w_idx} < NCH4);
   assign w_unused_bits = ^{addr[31:6], addr[1:0], wdata[31:16], wdata[7:3]};

   always_comb begin
      w_rd_val = '0;
      if (w_idx_ok) begin
         if (w_sel) w_rd_val = {16'b0, r_duty[w_idx], 5'b0, r_wave[w_idx]};
         else       w_rd_val = {16'b0, r_freq[w_idx]};
      end
   end

   // Channel k owns the update slot at fc == k+1; all channels share one datapath.
   always_comb begin
      w_slot_hit = 1'b0;
      w_slot     = '0;
      for (int k = 0; k < N_CH; k++) begin
         if (r_fc == FCW'(k + 1)) begin
            w_slot_hit = 1'b1;
            w_slot     = 3'(k);
         end
      end
   end

   assign w_ph = r_phase[w_slot];
   assign w_p  = w_ph[15:8];

   always_comb begin
      w_sample = 8'h00;
      w_kill   = 1'b0;
      case (wave_e'(r_wave[w_slot]))
         W_SQUARE: w_sample = (w_p < r_duty[w_slot]) ? 8'hFF : 8'h00;
         W_SAW:    w_sample = w_p;
         W_TRI:    w_sample = w_ph[15] ? ~w_ph[14:7] : w_ph[14:7];
`ifdef TONE_GEN_NOISE_EN
         W_NOISE:  w_sample = r_lfsr[7:0];
`endif
         default:  w_kill = 1'b1;
      endcase
   end

`ifdef TONE_GEN_NOISE_EN
   assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
   assign w_is_noise = (r_wave[w_slot] == W_NOISE);
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         for (int k = 0; k < 8; k++) begin
            r_freq[k]  <= '0;
            r_wave[k]  <= '0;
            r_duty[k]  <= '0;
            r_phase[k] <= '0;
            r_ch[k]    <= '0;
         end
         r_fc    <= '0;
         r_ready <= 1'b0;
         r_rdata <= '0;
         r_frame <= 1'b0;
`ifdef TONE_GEN_NOISE_EN
         r_lfsr  <= 16'hACE1;
`endif
      end else begin
         r_ready <= w_acc;
         r_rdata <= (w_acc && !w_wr) ? w_rd_val : '0;
         r_fc    <= (r_fc == FCW'(DIV - 1)) ? '0 : r_fc + 1'b1;
         r_frame <= (r_fc == FCW'(N_CH));
         if (w_slot_hit) begin
            r_ch[w_slot]    <= w_sample;
            r_phase[w_slot] <= w_kill ? 16'h0000 : w_ph + r_freq[w_slot];
`ifdef TONE_GEN_NOISE_EN
            if (w_is_noise) r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
`endif
         end
         // NOTE: the CTRL phase clear comes after the slot update so it wins when both hit one channel.
         if (w_acc && w_wr && w_idx_ok) begin
            if (w_sel) begin
               r_wave[w_idx]  <= wdata[2:0];
               r_duty[w_idx]  <= wdata[15:8];
               r_phase[w_idx] <= '0;
            end else begin
               r_freq[w_idx]  <= wdata[15:0];
            end
         end
      end
   end

   assign ready = r_ready;
   assign rdata = r_rdata;
   assign frame = r_frame;
   assign ch0   = r_ch[0];
   assign ch1   = r_ch[1];
   assign ch2   = r_ch[2];
   assign ch3   = r_ch[3];
   assign ch4   = r_ch[4];
   assign ch5   = r_ch[5];
   assign ch6   = r_ch[6];
   assign ch7   = r_ch[7];

endmodule

// File: tb/tb_tone_gen.sv
// Bench for tone_gen: an 8-channel and a 4-channel instance share one bus and are checked
// against a frame-level reference model (phase per frame, waveform rules, LFSR from ACE1).
`timescale 1ns/1ps
module tb_tone_gen;

   localparam int DIV  = 16;
   localparam int FR8  = 9;
   localparam int FR4  = 5;
   localparam int WRFC = 11;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        valid = 1'b0;
   logic [3:0]  wstrb = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic        ready8, ready4, frame8, frame4;
   logic [31:0] rdata8, rdata4;
   logic [7:0]  ch8 [8];
   logic [7:0]  ch4 [8];

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;

   int m_n     [2] = '{8, 4};
   int m_freq  [2][8];
   int m_wave  [2][8];
   int m_duty  [2][8];
   int m_phase [2][8];
   int m_out   [2][8];
   int m_lfsr  [2];

   always #5 clk = ~clk;
   always @(posedge clk) if (!resetn) cyc <= 0; else cyc <= cyc + 1;

   tone_gen #(.N_CH(8), .DIV(DIV)) u_dut8 (
      .clk(clk), .resetn(resetn), .valid(valid), .ready(ready8), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .rdata(rdata8),
      .ch0(ch8[0]), .ch1(ch8[1]), .ch2(ch8[2]), .ch3(ch8[3]),
      .ch4(ch8[4]), .ch5(ch8[5]), .ch6(ch8[6]), .ch7(ch8[7]), .frame(frame8));

   tone_gen #(.N_CH(4), .DIV(DIV)) u_dut4 (
      .clk(clk), .resetn(resetn), .valid(valid), .ready(ready4), .wstrb(wstrb),
      .addr(addr), .wdata(wdata), .rdata(rdata4),
      .ch0(ch4[0]), .ch1(ch4[1]), .ch2(ch4[2]), .ch3(ch4[3]),
      .ch4(ch4[4]), .ch5(ch4[5]), .ch6(ch4[6]), .ch7(ch4[7]), .frame(frame4));

   // ---------------- reference model ----------------
   function automatic int wave_val(int wave, int duty, int phase, int lfsr);
      int p = phase / 256;
      int t = (phase / 128) % 256;
      case (wave)
         1: return (p < duty) ? 255 : 0;
         2: return p;
         3: return (phase >= 32768) ? 255 - t : t;
`ifdef TONE_GEN_NOISE_EN
         4: return lfsr % 256;
`endif
         default: return 0;
      endcase
   endfunction

   function automatic bit wave_runs(int wave);
`ifdef TONE_GEN_NOISE_EN
      return (wave >= 1 && wave <= 4);
`else
      return (wave >= 1 && wave <= 3);
`endif
   endfunction

   function automatic int lfsr_next(int l);
      int b = (l ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
      return (l >> 1) | (b << 15);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < 8; k++) begin
            m_freq[i][k] = 0; m_wave[i][k] = 0; m_duty[i][k] = 0;
            m_phase[i][k] = 0; m_out[i][k] = 0;
         end
         m_lfsr[i] = 'hACE1;
      end
   endtask

   task automatic model_frame();
      for (int i = 0; i < 2; i++) begin
         for (int k = 0; k < m_n[i]; k++) begin
            m_out[i][k] = wave_val(m_wave[i][k], m_duty[i][k], m_phase[i][k], m_lfsr[i]);
`ifdef TONE_GEN_NOISE_EN
            if (m_wave[i][k] == 4) m_lfsr[i] = lfsr_next(m_lfsr[i]);
`endif
            m_phase[i][k] = wave_runs(m_wave[i][k]) ? (m_phase[i][k] + m_freq[i][k]) % 65536 : 0;
         end
      end
   endtask

   task automatic model_wr(int ch, int sel, logic [31:0] data);
      for (int i = 0; i < 2; i++) begin
         if (ch < m_n[i]) begin
            if (sel != 0) begin
               m_wave[i][ch]  = int'(data[2:0]);
               m_duty[i][ch]  = int'(data[15:8]);
               m_phase[i][ch] = 0;
            end else begin
               m_freq[i][ch]  = int'(data[15:0]);
            end
         end
      end
   endtask

   function automatic int model_rd(int i, int ch, int sel);
      if (ch >= m_n[i]) return 0;
      return (sel != 0) ? (m_duty[i][ch] * 256 + m_wave[i][ch]) : m_freq[i][ch];
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic do_reset(int ncyc);
      resetn = 1'b0;
      repeat (ncyc) @(posedge clk);
      #1;
      resetn = 1'b1;
      model_reset();
   endtask

   task automatic goto_fc(int v);
      int n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while ((cyc % DIV) != v && n < 2 * DIV);
      if ((cyc % DIV) != v) begin
         n_err++;
         $display("FAIL goto_fc: counter at %0d, wanted %0d", cyc % DIV, v);
      end
   endtask

   task automatic set_addr(int ch, int sel);
      addr = ($urandom & 32'hFFFF_FFC3) | (32'(sel) << 5) | (32'(ch) << 2);
   endtask

   task automatic bus_wr(int ch, int sel, logic [31:0] data);
      valid = 1'b1;
      wstrb = 4'($urandom_range(1, 15));
      set_addr(ch, sel);
      wdata = data;
      @(posedge clk); #1;
      valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic bus_rd(int ch, int sel, output logic [31:0] d8, output logic [31:0] d4);
      valid = 1'b1;
      wstrb = 4'b0000;
      set_addr(ch, sel);
      wdata = $urandom;
      @(posedge clk); #1;
      d8 = rdata8;
      d4 = rdata4;
      valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic frame_step();
      goto_fc(FR8);
      model_frame();
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] d8, d4;
      do_reset(3);
      for (int k = 0; k < 8; k++) begin
         n_cmp++;
         if (ch8[k] !== 8'h00 || ch4[k] !== 8'h00) begin
            n_err++; $display("FAIL reset_ch[%0d]: got %02h/%02h exp 00", k, ch8[k], ch4[k]);
         end
      end
      n_cmp++;
      if ({ready8, ready4, frame8, frame4} !== 4'b0000) begin
         n_err++; $display("FAIL reset_ctl: ready/frame got %b exp 0000", {ready8, ready4, frame8, frame4});
      end
      n_cmp++;
      if (rdata8 !== 32'h0) begin
         n_err++; $display("FAIL reset_rdata: got %08h exp 0", rdata8);
      end
      bus_rd(0, 1, d8, d4);
      n_cmp++;
      if (d8 !== 32'h0 || d4 !== 32'h0) begin
         n_err++; $display("FAIL reset_ctrl_rd: got %08h/%08h exp 0", d8, d4);
      end
   endtask

   task automatic test_saw();
      do_reset(2);
      goto_fc(WRFC);
      bus_wr(0, 0, 32'h0000_0100); model_wr(0, 0, 32'h0000_0100);
      bus_wr(0, 1, 32'h0000_0002); model_wr(0, 1, 32'h0000_0002);
      for (int f = 0; f < 257; f++) begin
         if (f < 3) begin
            goto_fc(FR4);
            n_cmp++;
            if (frame4 !== 1'b1 || frame8 !== 1'b0) begin
               n_err++; $display("FAIL saw_frame4 f%0d: got %b/%b exp 1/0", f, frame4, frame8);
            end
            goto_fc(FR8 - 1);
            n_cmp++;
            if (frame8 !== 1'b0) begin
               n_err++; $display("FAIL saw_frame_early f%0d: got %b exp 0", f, frame8);
            end
         end
         frame_step();
         n_cmp++;
         if (frame8 !== 1'b1) begin
            n_err++; $display("FAIL saw_frame f%0d: got %b exp 1", f, frame8);
         end
         n_cmp++;
         if (ch8[0] !== 8'(m_out[0][0]) || ch4[0] !== 8'(m_out[1][0]) || ch8[0] !== 8'(f % 256)) begin
            n_err++; $display("FAIL saw_ch0 f%0d: got %02h/%02h exp %02h", f, ch8[0], ch4[0], m_out[0][0]);
         end
      end
   endtask

   task automatic test_square();
      do_reset(2);
      goto_fc(WRFC);
      bus_wr(3, 0, 32'h0000_1000); model_wr(3, 0, 32'h0000_1000);
      bus_wr(3, 1, 32'h0000_8001); model_wr(3, 1, 32'h0000_8001);
      for (int f = 0; f < 24; f++) begin
         frame_step();
         n_cmp++;
         if (ch8[3] !== 8'(m_out[0][3]) || ch4[3] !== 8'(m_out[1][3]) ||
             ch8[3] !== (((f / 8) % 2 == 0) ? 8'hFF : 8'h00)) begin
            n_err++; $display("FAIL square_ch3 f%0d: got %02h/%02h exp %02h", f, ch8[3], ch4[3], m_out[0][3]);
         end
      end
   endtask

   task automatic test_triangle();
      logic [31:0] d8, d4;
      do_reset(2);
      goto_fc(WRFC);
      bus_wr(5, 0, 32'h0000_0800); model_wr(5, 0, 32'h0000_0800);
      bus_wr(5, 1, 32'h0000_0003); model_wr(5, 1, 32'h0000_0003);
      for (int f = 0; f < 34; f++) begin
         frame_step();
         n_cmp++;
         if (ch8[5] !== 8'(m_out[0][5]) || ch4[5] !== 8'h00) begin
            n_err++; $display("FAIL tri_ch5 f%0d: got %02h/%02h exp %02h/00", f, ch8[5], ch4[5], m_out[0][5]);
         end
      end
      bus_rd(5, 0, d8, d4);
      n_cmp++;
      if (d8 !== 32'h0000_0800 || d4 !== 32'h0) begin
         n_err++; $display("FAIL tri_freq_rd: got %08h/%08h exp 00000800/0", d8, d4);
      end
      bus_rd(5, 1, d8, d4);
      n_cmp++;
      if (d8 !== 32'h0000_0003 || d4 !== 32'h0) begin
         n_err++; $display("FAIL tri_ctrl_rd: got %08h/%08h exp 00000003/0", d8, d4);
      end
   endtask

   task automatic test_bus();
      logic [31:0] d8, d4;
      logic [3:0]  seen;
      logic [31:0] junk;
      do_reset(2);
      valid = 1'b1; wstrb = 4'b0000; set_addr(0, 0);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         seen[i] = ready8 & ready4;
      end
      valid = 1'b0;
      n_cmp++;
      if (seen !== 4'b0101) begin
         n_err++; $display("FAIL bus_held_valid: ready pattern got %b exp 0101", seen);
      end
      @(posedge clk); #1;
      n_cmp++;
      if (ready8 !== 1'b0 || ready4 !== 1'b0) begin
         n_err++; $display("FAIL bus_ready_idle: got %b/%b exp 0/0", ready8, ready4);
      end
      bus_wr(7, 0, 32'h1234_BEEF); model_wr(7, 0, 32'h1234_BEEF);
      bus_rd(7, 0, d8, d4);
      n_cmp++;
      if (d8 !== 32'(model_rd(0, 7, 0)) || d4 !== 32'h0) begin
         n_err++; $display("FAIL bus_ch7_drop: got %08h/%08h exp %08h/0", d8, d4, model_rd(0, 7, 0));
      end
      junk = {$urandom, 16'hA500} | 32'h6;
      junk[7:3] = 5'($urandom);
      bus_wr(2, 1, junk); model_wr(2, 1, junk);
      bus_rd(2, 1, d8, d4);
      n_cmp++;
      if (d8 !== 32'(model_rd(0, 2, 1)) || d4 !== 32'(model_rd(1, 2, 1))) begin
         n_err++; $display("FAIL bus_ctrl_rd: got %08h/%08h exp %08h", d8, d4, model_rd(0, 2, 1));
      end
      // collision: CTRL rewrite lands exactly in channel 2's update slot
      do_reset(1);
      goto_fc(WRFC);
      bus_wr(2, 0, 32'h0000_1000); model_wr(2, 0, 32'h0000_1000);
      bus_wr(2, 1, 32'h0000_0002); model_wr(2, 1, 32'h0000_0002);
      for (int f = 0; f < 3; f++) frame_step();
      goto_fc(3);
      bus_wr(2, 1, 32'h0000_0002);
      for (int f = 0; f < 3; f++) begin
         frame_step();
         if (f == 0) begin
            m_phase[0][2] = 0;
            m_phase[1][2] = 0;
         end
         n_cmp++;
         if (ch8[2] !== 8'(m_out[0][2]) || ch4[2] !== 8'(m_out[1][2])) begin
            n_err++; $display("FAIL bus_collision f%0d: got %02h/%02h exp %02h", f, ch8[2], ch4[2], m_out[0][2]);
         end
      end
   endtask

   task automatic test_noise();
      do_reset(2);
      goto_fc(WRFC);
      bus_wr(1, 0, 32'($urandom_range(0, 65535))); model_wr(1, 0, 32'h0);
      m_freq[0][1] = 0; m_freq[1][1] = 0;
      bus_wr(1, 0, 32'h0000_0321); model_wr(1, 0, 32'h0000_0321);
      bus_wr(1, 1, 32'h0000_0004); model_wr(1, 1, 32'h0000_0004);
      for (int f = 0; f < 12; f++) begin
         frame_step();
         n_cmp++;
         if (ch8[1] !== 8'(m_out[0][1]) || ch4[1] !== 8'(m_out[1][1])) begin
            n_err++; $display("FAIL noise_ch1 f%0d: got %02h/%02h exp %02h", f, ch8[1], ch4[1], m_out[0][1]);
         end
`ifndef TONE_GEN_NOISE_EN
         n_cmp++;
         if (ch8[1] !== 8'h00) begin
            n_err++; $display("FAIL noise_off_ch1 f%0d: got %02h exp 00", f, ch8[1]);
         end
`endif
      end
   endtask

   task automatic test_random();
      logic [31:0] d8, d4, v;
      int ch, sel;
      do_reset(2);
      for (int k = 0; k < 8; k++) begin
         v = $urandom;
         bus_wr(k, 0, v); model_wr(k, 0, v);
      end
      for (int f = 0; f < 14; f++) begin
         goto_fc(WRFC);
         if (f < 8) begin
            v = $urandom;
            bus_wr(f, 1, v); model_wr(f, 1, v);
         end else if (f == 10) begin
            v = $urandom;
            bus_wr(0, 0, v); model_wr(0, 0, v);
         end
         frame_step();
         for (int k = 0; k < 8; k++) begin
            n_cmp++;
            if (ch8[k] !== 8'(m_out[0][k]) || ch4[k] !== 8'(m_out[1][k])) begin
               n_err++; $display("FAIL rand_ch[%0d] f%0d: got %02h/%02h exp %02h/%02h",
                                 k, f, ch8[k], ch4[k], m_out[0][k], m_out[1][k]);
            end
         end
      end
      for (int i = 0; i < 8; i++) begin
         ch  = $urandom_range(0, 7);
         sel = $urandom_range(0, 1);
         bus_rd(ch, sel, d8, d4);
         n_cmp++;
         if (d8 !== 32'(model_rd(0, ch, sel)) || d4 !== 32'(model_rd(1, ch, sel))) begin
            n_err++; $display("FAIL rand_rd ch%0d sel%0d: got %08h/%08h exp %08h/%08h",
                              ch, sel, d8, d4, model_rd(0, ch, sel), model_rd(1, ch, sel));
         end
      end
   endtask

   task automatic test_reset_midframe();
      logic [31:0] d8, d4;
      do_reset(2);
      goto_fc(WRFC);
      bus_wr(0, 0, 32'h0000_2000);
      bus_wr(0, 1, 32'h0000_0002);
      goto_fc(FR8);
      goto_fc(FR8);
      goto_fc(FR8 - 1);
      resetn = 1'b0;
      @(posedge clk); #1;
      n_cmp++;
      if (frame8 !== 1'b0 || ch8[0] !== 8'h00) begin
         n_err++; $display("FAIL midreset_state: frame %b ch0 %02h exp 0/00", frame8, ch8[0]);
      end
      resetn = 1'b1;
      model_reset();
      goto_fc(FR8 - 1);
      n_cmp++;
      if (frame8 !== 1'b0) begin
         n_err++; $display("FAIL midreset_early_frame: got %b exp 0", frame8);
      end
      goto_fc(FR8);
      n_cmp++;
      if (frame8 !== 1'b1 || ch8[0] !== 8'h00) begin
         n_err++; $display("FAIL midreset_restart: frame %b ch0 %02h exp 1/00", frame8, ch8[0]);
      end
      bus_rd(0, 1, d8, d4);
      n_cmp++;
      if (d8 !== 32'h0) begin
         n_err++; $display("FAIL midreset_ctrl_rd: got %08h exp 0", d8);
      end
   endtask

   initial begin
      test_reset();
      test_saw();
      test_square();
      test_triangle();
      test_bus();
      test_noise();
      test_random();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
